// File: rtl/cache_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cache_sram_bridge
//  Description : Serialises cache line refills / writebacks and uncached
//                accesses into single-outstanding 32-bit SRAM-bus beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_sram_bridge #(
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic         mem_req,
    output logic         mem_wr,
    output logic [1:0]   mem_size,
    output logic [31:0]  mem_addr,
    output logic [3:0]   mem_wstrb,
    output logic [31:0]  mem_wdata,
    input  logic         mem_addr_ok,
    input  logic         mem_data_ok,
    input  logic [31:0]  mem_rdata
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_REQ  = 3'd1;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd2;
    localparam logic [2:0] c_ST_WR_REQ  = 3'd3;
    localparam logic [2:0] c_ST_WR_WAIT = 3'd4;
    localparam logic [2:0] c_TYPE_LINE  = 3'b100;
    localparam logic [1:0] c_LAST_CNT   = 2'(LINE_WORDS - 1);

    logic [2:0]   r_state;
    logic [1:0]   r_cnt;
    logic [2:0]   r_type;
    logic [31:0]  r_addr;
    logic [127:0] r_wdata;

    logic         w_line;
    logic         w_last_beat;
    logic [1:0]   w_cnt_nxt;

    // Unlisted size encodings fall back to a full word.
    function automatic logic [1:0] size_of(input logic [2:0] t);
        case (t)
            3'b000:  size_of = 2'd0;
            3'b001:  size_of = 2'd1;
            default: size_of = 2'd2;
        endcase
    endfunction

    function automatic logic [31:0] beat_addr(input logic [2:0] t, input logic [31:0] a,
                                              input logic [1:0] k);
        beat_addr = (t == c_TYPE_LINE) ? {a[31:4], k, 2'b00} : a;
    endfunction

    assign w_line      = (r_type == c_TYPE_LINE);
    assign w_last_beat = w_line ? (r_cnt == c_LAST_CNT) : 1'b1;
    assign w_cnt_nxt   = r_cnt + 2'd1;

    // Writes win over reads so a dirty victim always leaves before its refill.
    assign wr_rdy = (r_state == c_ST_IDLE);
    assign rd_rdy = wr_rdy & ~wr_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 2'd0;
            r_type    <= 3'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 128'd0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_size  <= 2'd0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
            ret_valid <= 1'b0;
            ret_last  <= 1'b0;
            ret_data  <= 32'd0;
        end else begin
            ret_valid <= 1'b0;
            ret_last  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (wr_req) begin
                        r_type    <= wr_type;
                        r_addr    <= wr_addr;
                        r_wdata   <= wr_data;
                        r_cnt     <= 2'd0;
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_size  <= size_of(wr_type);
                        mem_addr  <= beat_addr(wr_type, wr_addr, 2'd0);
                        mem_wstrb <= (wr_type == c_TYPE_LINE) ? 4'hf : wr_wstrb;
                        mem_wdata <= wr_data[31:0];
                        r_state   <= c_ST_WR_REQ;
                    end else if (rd_req) begin
                        r_type    <= rd_type;
                        r_addr    <= rd_addr;
                        r_cnt     <= 2'd0;
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_size  <= size_of(rd_type);
                        mem_addr  <= beat_addr(rd_type, rd_addr, 2'd0);
                        mem_wstrb <= 4'd0;
                        mem_wdata <= 32'd0;
                        r_state   <= c_ST_RD_REQ;
                    end
                end
                c_ST_RD_REQ: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        r_state <= c_ST_RD_WAIT;
                    end
                end
                c_ST_RD_WAIT: begin
                    if (mem_data_ok) begin
                        ret_valid <= 1'b1;
                        ret_last  <= w_last_beat;
                        ret_data  <= mem_rdata;
                        if (w_last_beat) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cnt    <= w_cnt_nxt;
                            mem_req  <= 1'b1;
                            mem_addr <= beat_addr(r_type, r_addr, w_cnt_nxt);
                            r_state  <= c_ST_RD_REQ;
                        end
                    end
                end
                c_ST_WR_REQ: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        r_state <= c_ST_WR_WAIT;
                    end
                end
                c_ST_WR_WAIT: begin
                    if (mem_data_ok) begin
                        if (w_last_beat) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cnt     <= w_cnt_nxt;
                            mem_req   <= 1'b1;
                            mem_addr  <= beat_addr(r_type, r_addr, w_cnt_nxt);
                            mem_wdata <= r_wdata[{w_cnt_nxt, 5'd0} +: 32];
                            r_state   <= c_ST_WR_REQ;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_sram_bridge
//  Description : Directed bench with a memory model and request/return
//                scoreboards for cache_sram_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_sram_bridge;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } ret_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic         mem_req;
    logic         mem_wr;
    logic [1:0]   mem_size;
    logic [31:0]  mem_addr;
    logic [3:0]   mem_wstrb;
    logic [31:0]  mem_wdata;
    logic         mem_addr_ok;
    logic         mem_data_ok;
    logic [31:0]  mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    req_t exp_req[$];
    ret_t exp_ret[$];
    logic [31:0] mem [logic [31:0]];

    int data_wait  = 0;
    int stall_idx  = -1;
    int stall_len  = 0;
    int stall_seen = 0;
    int reqn       = 0;
    bit stray_req  = 1'b0;

    always #5 clk = ~clk;

    cache_sram_bridge #(.LINE_WORDS(4)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [3:0] wstrb, input logic [31:0] wdata);
        req_t r;
        r.wr = wr; r.size = size; r.addr = addr; r.wstrb = wstrb; r.wdata = wdata;
        exp_req.push_back(r);
    endtask

    task automatic push_ret(input logic [31:0] data, input logic last);
        ret_t r;
        r.data = data; r.last = last;
        exp_ret.push_back(r);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return mem.exists(k) ? mem[k] : 32'd0;
    endfunction

    // Memory model: optional addr_ok stall on one chosen request, data_ok after data_wait.
    initial begin
        bit          pend;
        bit          pend_wr;
        int          dcnt;
        int          acnt;
        logic [31:0] rd_word;
        logic [31:0] w;
        req_t        e;
        pend = 0; pend_wr = 0; dcnt = 0; acnt = 0; rd_word = 0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            if (reset) begin
                pend = 0;
                acnt = 0;
            end else if (stray_req) begin
                mem_data_ok = 1'b1;
                mem_rdata   = 32'hBAD0_BAD0;
                stray_req   = 1'b0;
            end else if (pend) begin
                if (dcnt == 0) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = pend_wr ? 32'd0 : rd_word;
                    pend        = 0;
                end else begin
                    dcnt--;
                end
            end else if (mem_req) begin
                if (reqn == stall_idx && acnt < stall_len) begin
                    acnt++;
                    stall_seen++;
                    if (exp_req.size() > 0) check("bp_addr_held", mem_addr, exp_req[0].addr);
                end else begin
                    mem_addr_ok = 1'b1;
                    acnt = 0;
                    reqn++;
                    if (exp_req.size() == 0) begin
                        check("req_unexpected", {31'd0, mem_req}, 32'd0);
                    end else begin
                        e = exp_req.pop_front();
                        check("req_wr", {31'd0, mem_wr}, {31'd0, e.wr});
                        check("req_size", {30'd0, mem_size}, {30'd0, e.size});
                        check("req_addr", mem_addr, e.addr);
                        if (e.wr) begin
                            check("req_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
                            check("req_wdata", mem_wdata, e.wdata);
                        end
                    end
                    if (mem_wr) begin
                        w = mem_rd(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem[{mem_addr[31:2], 2'b00}] = w;
                    end else begin
                        rd_word = mem_rd(mem_addr);
                    end
                    pend    = 1;
                    pend_wr = mem_wr;
                    dcnt    = data_wait;
                end
            end
        end
    end

    // Return-beat scoreboard.
    initial begin
        ret_t e;
        forever begin
            @(negedge clk);
            if (ret_valid) begin
                if (exp_ret.size() == 0) begin
                    check("ret_unexpected", {31'd0, ret_valid}, 32'd0);
                end else begin
                    e = exp_ret.pop_front();
                    check("ret_data", ret_data, e.data);
                    check("ret_last", {31'd0, ret_last}, {31'd0, e.last});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drain();
        int n = 0;
        while ((exp_req.size() != 0 || exp_ret.size() != 0 || !wr_rdy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_req_q", 32'(exp_req.size()), 32'd0);
        check("drain_ret_q", 32'(exp_ret.size()), 32'd0);
        check("drain_wr_rdy", {31'd0, wr_rdy}, 32'd1);
    endtask

    task automatic do_rd(input logic [2:0] t, input logic [31:0] a);
        @(negedge clk);
        rd_req = 1'b1; rd_type = t; rd_addr = a;
        #1 check("rd_accept", {31'd0, rd_rdy}, 32'd1);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic do_wr(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                         input logic [127:0] d);
        @(negedge clk);
        wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
        #1 check("wr_accept", {31'd0, wr_rdy}, 32'd1);
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rd_req = 1'b0; rd_type = 3'd0; rd_addr = 32'd0;
        wr_req = 1'b1; wr_type = 3'd0; wr_addr = 32'd0; wr_wstrb = 4'd0; wr_data = 128'd0;

        // Reset state
        #1 check("rst_rd_rdy_wr_req", {31'd0, rd_rdy}, 32'd0);
        wr_req = 1'b0;
        #1 check("rst_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        check("rst_wr_rdy", {31'd0, wr_rdy}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_size", {30'd0, mem_size}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_ret_valid", {31'd0, ret_valid}, 32'd0);
        check("rst_ret_last", {31'd0, ret_last}, 32'd0);
        check("rst_ret_data", ret_data, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // Line refill with exact beat timing
        for (int k = 0; k < 4; k++) begin
            mem[32'h1C00_0040 + 32'(4*k)] = 32'hA0 + 32'(k);
            push_req(1'b0, 2'd2, 32'h1C00_0040 + 32'(4*k), 4'd0, 32'd0);
            push_ret(32'hA0 + 32'(k), k == 3);
        end
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C00_0048;
        #1 check("refill_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rd_req = 1'b0;
                check("refill_mem_req_t1", {31'd0, mem_req}, 32'd1);
                check("refill_mem_addr_t1", mem_addr, 32'h1C00_0040);
            end
            check($sformatf("refill_ret_valid_t%0d", k), {31'd0, ret_valid},
                  {31'd0, (k >= 3 && (k % 2) == 1)});
            if (k == 9) check("refill_rd_rdy_t9", {31'd0, rd_rdy}, 32'd1);
        end
        drain();

        // Writeback then refill of the same line, requested together
        for (int k = 0; k < 4; k++)
            push_req(1'b1, 2'd2, 32'h0000_1230 + 32'(4*k), 4'hf, 32'h11 * 32'(k));
        for (int k = 0; k < 4; k++) begin
            push_req(1'b0, 2'd2, 32'h0000_1230 + 32'(4*k), 4'd0, 32'd0);
            push_ret(32'h11 * 32'(k), k == 3);
        end
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_1234; wr_wstrb = 4'h0;
        wr_data = {32'h33, 32'h22, 32'h11, 32'h00};
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_1230;
        #1 check("wb_rd_rdy_t0", {31'd0, rd_rdy}, 32'd0);
        check("wb_wr_rdy_t0", {31'd0, wr_rdy}, 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) wr_req = 1'b0;
            #1 check($sformatf("wb_rd_rdy_t%0d", k), {31'd0, rd_rdy}, {31'd0, k == 9});
        end
        @(negedge clk);
        rd_req = 1'b0;
        drain();

        // Uncached byte write
        push_req(1'b1, 2'd0, 32'hBFAF_F002, 4'b0100, 32'h00AB_0000);
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'hBFAF_F002; wr_wstrb = 4'b0100;
        wr_data = {96'd0, 32'h00AB_0000};
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) wr_req = 1'b0;
            #1 check($sformatf("bytewr_wr_rdy_t%0d", k), {31'd0, wr_rdy}, {31'd0, k == 3});
        end
        drain();

        // Backpressure on line beat 2
        for (int k = 0; k < 4; k++) begin
            push_req(1'b0, 2'd2, 32'h1C00_0040 + 32'(4*k), 4'd0, 32'd0);
            push_ret(32'hA0 + 32'(k), k == 3);
        end
        reqn = 0; stall_seen = 0; stall_idx = 2; stall_len = 5;
        do_rd(3'b100, 32'h1C00_004F);
        drain();
        stall_idx = -1;
        check("bp_stall_cycles", 32'(stall_seen), 32'd5);

        // Async reset mid-refill
        for (int k = 0; k < 4; k++) begin
            push_req(1'b0, 2'd2, 32'h1C00_0040 + 32'(4*k), 4'd0, 32'd0);
            push_ret(32'hA0 + 32'(k), k == 3);
        end
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C00_0040;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) rd_req = 1'b0;
        end
        check("arst_ret_valid_before", {31'd0, ret_valid}, 32'd1);
        check("arst_mem_req_before", {31'd0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1 check("arst_ret_valid", {31'd0, ret_valid}, 32'd0);
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        exp_req.delete();
        exp_ret.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        stray_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1 check($sformatf("arst_stray_ret_valid_%0d", k), {31'd0, ret_valid}, 32'd0);
            check($sformatf("arst_rd_rdy_%0d", k), {31'd0, rd_rdy}, 32'd1);
        end

        // Uncached word read with a slow data phase
        data_wait = 3;
        mem[32'h1FD0_F010] = 32'hDEAD_BEEF;
        push_req(1'b0, 2'd2, 32'h1FD0_F010, 4'd0, 32'd0);
        push_ret(32'hDEAD_BEEF, 1'b1);
        do_rd(3'b010, 32'h1FD0_F010);
        drain();
        data_wait = 0;

        // Unlisted read type behaves as a word
        mem[32'h1FD0_F014] = 32'h1234_5678;
        push_req(1'b0, 2'd2, 32'h1FD0_F014, 4'd0, 32'd0);
        push_ret(32'h1234_5678, 1'b1);
        do_rd(3'b111, 32'h1FD0_F014);
        drain();

        // Halfword write merged into memory, then read back
        push_req(1'b1, 2'd1, 32'h1FD0_F016, 4'b1100, 32'hCAFE_0000);
        do_wr(3'b001, 32'h1FD0_F016, 4'b1100, {96'd0, 32'hCAFE_0000});
        drain();
        push_req(1'b0, 2'd2, 32'h1FD0_F014, 4'd0, 32'd0);
        push_ret(32'hCAFE_5678, 1'b1);
        do_rd(3'b010, 32'h1FD0_F014);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
